pipelined_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_segment.sv | 34 +++
 rtl/pipelined_adder.sv | 152 +++++++++++++++
 tb/tb_pipelined_adder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder.
//   MODE_ADD / MODE_SUB : encoding of the sub input
//   calc_nseg()         : number of carry-chain segments (pipeline stages);
//                         returns 0 for an illegal WIDTH/SEG_W combination so
//                         the top level can reject it at elaboration.
package adder_pkg;

  localparam bit MODE_ADD = 1'b0;
  localparam bit MODE_SUB = 1'b1;

  function automatic int calc_nseg(input int width, input int seg_w);
    if (width < 1 || seg_w < 1 || (width % seg_w) != 0) begin
      return 0;
    end
    return width / seg_w;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG_W-bit ripple adder built from per-bit full-adder equations.
// Ports:
//   a_seg, b_seg : segment operands (b already inverted for subtraction)
//   ci           : carry into bit 0 of the segment
//   s_seg        : segment sum
//   co           : carry out of the segment MSB
//   c_msb_in     : carry into the segment MSB (signed-overflow detection)
module adder_segment #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             ci,
  output logic [SEG_W-1:0] s_seg,
  output logic             co,
  output logic             c_msb_in
);

  logic [SEG_W:0] c;

  always_comb begin
    c     = '0;
    s_seg = '0;
    c[0]  = ci;
    for (int i = 0; i < SEG_W; i++) begin
      s_seg[i] = a_seg[i] ^ b_seg[i] ^ c[i];
      c[i+1]   = (a_seg[i] & b_seg[i]) | (c[i] & (a_seg[i] ^ b_seg[i]));
    end
  end

  assign co       = c[SEG_W];
  assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into NSEG
// segments of SEG_W bits, one register stage per segment, so latency is NSEG
// cycles and throughput is one beat per cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake
//   a, b, cin, sub      : operands; sub=1 computes a + ~b + 1 (cin ignored)
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, carry out of MSB, signed overflow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);

  if (NSEG < 1) begin : g_param_check
    $error("pipelined_adder: WIDTH=%0d must be a positive multiple of SEG_W=%0d", WIDTH, SEG_W);
  end

  logic advance;

  // Operand registers hold the not-yet-added upper segments, shifted down so
  // the next stage always consumes bits [SEG_W-1:0]. Result registers collect
  // finished segments from the top, so after NSEG stages they are in order.
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] res_q [NSEG];
  logic [NSEG-1:0]  vld_q;
  logic [NSEG-1:0]  cy_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_d   [NSEG];
  logic [WIDTH-1:0] b_d   [NSEG];
  logic [WIDTH-1:0] res_d [NSEG];
  logic [NSEG-1:0]  vld_d;
  logic [NSEG-1:0]  cy_d;
  logic             ovf_d;

  logic [WIDTH-1:0] a_in  [NSEG];
  logic [WIDTH-1:0] b_in  [NSEG];
  logic [WIDTH-1:0] r_in  [NSEG];
  logic [NSEG-1:0]  c_in;
  logic [SEG_W-1:0] s_seg [NSEG];
  logic [NSEG-1:0]  co_seg;
  logic             c_msb_last;

  // Single global enable: the whole pipe moves or nothing moves.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    vld_d = '0;
    c_in  = '0;
    for (int k = 0; k < NSEG; k++) begin
      a_in[k] = '0;
      b_in[k] = '0;
      r_in[k] = '0;
    end
    a_in[0]  = a;
    b_in[0]  = (sub == MODE_ADD) ? b : ~b;
    c_in[0]  = (sub == MODE_SUB) ? 1'b1 : cin;
    vld_d[0] = in_valid;
    for (int k = 1; k < NSEG; k++) begin
      a_in[k]  = a_q[k-1];
      b_in[k]  = b_q[k-1];
      r_in[k]  = res_q[k-1];
      c_in[k]  = cy_q[k-1];
      vld_d[k] = vld_q[k-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == NSEG - 1) begin : g_last
      adder_segment #(.SEG_W(SEG_W)) u_seg (
        .a_seg    (a_in[k][SEG_W-1:0]),
        .b_seg    (b_in[k][SEG_W-1:0]),
        .ci       (c_in[k]),
        .s_seg    (s_seg[k]),
        .co       (co_seg[k]),
        .c_msb_in (c_msb_last)
      );
    end else begin : g_mid
      // Carry into a segment MSB only matters for the top segment.
      logic c_msb_unused;
      adder_segment #(.SEG_W(SEG_W)) u_seg (
        .a_seg    (a_in[k][SEG_W-1:0]),
        .b_seg    (b_in[k][SEG_W-1:0]),
        .ci       (c_in[k]),
        .s_seg    (s_seg[k]),
        .co       (co_seg[k]),
        .c_msb_in (c_msb_unused)
      );
    end
  end

  always_comb begin
    cy_d = '0;
    for (int k = 0; k < NSEG; k++) begin
      a_d[k]   = a_in[k] >> SEG_W;
      b_d[k]   = b_in[k] >> SEG_W;
      res_d[k] = r_in[k] >> SEG_W;
      res_d[k][WIDTH-1 -: SEG_W] = s_seg[k];
      cy_d[k]  = co_seg[k];
    end
    ovf_d = c_msb_last ^ co_seg[NSEG-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
      end
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_q[NSEG-1];
  assign sum       = res_q[NSEG-1];
  assign cout      = cy_q[NSEG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  localparam int W   = 16;
  localparam int SW  = 4;
  localparam int LAT = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
    bit           chk_lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] b1 = '0;
  logic         cin1 = 1'b0;
  logic         sub1 = 1'b0;
  logic         out_valid1;
  logic         out_ready1 = 1'b1;
  logic [W-1:0] sum1;
  logic         cout1;
  logic         ovf1;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   dir_mode = 1'b0;
  exp_t dir_exp;

  pipelined_adder #(.WIDTH(W), .SEG_W(SW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(W), .SEG_W(W)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    exp_t e;
    int ua, ub, sa, sbv, r, t;
    ua  = int'(ma);
    ub  = int'(mb);
    sa  = ma[W-1] ? ua - 65536 : ua;
    sbv = mb[W-1] ? ub - 65536 : ub;
    if (msub) begin
      e.sum  = 16'(ua - ub);
      e.cout = (ua >= ub);
      r      = sa - sbv;
    end else begin
      t      = ua + ub + int'(mcin);
      e.sum  = 16'(t);
      e.cout = (t > 65535);
      r      = sa + sbv + int'(mcin);
    end
    e.ovf     = (r > 32767) || (r < -32768);
    e.cyc     = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  // Monitor / scoreboard: everything sampled at the falling edge, which sees
  // the values that the next rising edge will act on.
  initial begin
    exp_t        e;
    exp_t        p;
    bit          prev_stall;
    logic [17:0] prev_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        checks++;
        if (in_ready !== !(out_valid && !out_ready)) begin
          errors++;
          $display("FAIL in_ready actual=%b expected=%b", in_ready, !(out_valid && !out_ready));
        end
        if (prev_stall) begin
          checks++;
          if (out_valid !== 1'b1 || {sum, cout, ovf} !== prev_out) begin
            errors++;
            $display("FAIL stall_hold actual=%b/%h expected=1/%h", out_valid, {sum, cout, ovf}, prev_out);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output actual=%h expected=none", sum);
          end else begin
            e = exp_q.pop_front();
            if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
              errors++;
              $display("FAIL result actual=sum %h cout %b ovf %b expected=sum %h cout %b ovf %b",
                       sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            if (e.chk_lat) begin
              checks++;
              if (cyc - e.cyc != LAT) begin
                errors++;
                $display("FAIL latency actual=%0d expected=%0d", cyc - e.cyc, LAT);
              end
            end
          end
        end
        if (in_valid && in_ready) begin
          if (dir_mode) begin
            p = dir_exp;
            p.chk_lat = 1'b1;
          end else begin
            p = model(a, b, cin, sub);
          end
          p.cyc = cyc;
          exp_q.push_back(p);
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {sum, cout, ovf};
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                      input logic tsub, input bit dir, input logic [W-1:0] es,
                      input logic ec, input logic eo);
    @(posedge clk);
    #1;
    a            = ta;
    b            = tb_v;
    cin          = tcin;
    sub          = tsub;
    in_valid     = 1'b1;
    dir_mode     = dir;
    dir_exp.sum  = es;
    dir_exp.cout = ec;
    dir_exp.ovf  = eo;
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready 0 expected=1");
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dir_mode = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int sent;
    int guard;
    bit acc;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Directed beats, consumer always ready.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    idle();
    wait_cyc(8);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    idle();
    wait_cyc(8);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    idle();
    wait_cyc(8);

    // Random beats with a randomly stalling consumer.
    sent  = 0;
    guard = 0;
    acc   = 1'b0;
    while (sent < 32 && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        in_valid = 1'b0;
        acc      = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
        dir_mode = 1'b0;
        in_valid = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        sent++;
        acc = 1'b1;
      end
    end
    chk("random_beats_sent", 32'(sent), 32'd32);

    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    wait_cyc(LAT + 2);

    // Reset with three beats in flight.
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    send(16'h4321, 16'h0F0F, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    send(16'hAAAA, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum",       32'(sum),       32'd0);
    wait_cyc(LAT + 3);
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("post_rst_remaining", 32'(exp_q.size()), 32'd0);
    wait_cyc(LAT + 2);

    // Single-stage build.
    @(posedge clk);
    #1;
    a1        = 16'h1234;
    b1        = 16'h4321;
    cin1      = 1'b1;
    sub1      = 1'b0;
    in_valid1 = 1'b1;
    @(negedge clk);
    chk("nseg1_in_ready", 32'(in_ready1), 32'd1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("nseg1_out_valid", 32'(out_valid1), 32'd1);
    chk("nseg1_sum",       32'(sum1),       32'h5556);
    chk("nseg1_cout",      32'(cout1),      32'd0);
    chk("nseg1_ovf",       32'(ovf1),       32'd0);
    @(negedge clk);
    chk("nseg1_no_dup", 32'(out_valid1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
